seq_detect_multi: RTL and testbench

- Parametrised, runtime-programmable serial bit-sequence detector. Successor to the fixed two-pattern Moore detector.
- Watches one serial data line and compares it against NUM_PAT independent patterns of PAT_LEN bits each.
- Each pattern has its own enable, a selectable overlapping or non-overlapping matching mode, a one-cycle match flag and a saturating hit counter.
- Sits on the serial input path, between the bit source and the status/interrupt logic.

---
 rtl/seq_detect_multi.sv | 59 +++++
 tb/tb_seq_detect_multi.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_multi.sv
// seq_detect_multi: runtime-programmable serial detector for NUM_PAT patterns with
// per-pattern enable, overlap control, one-cycle match flags and saturating hit counters.
module seq_detect_multi #(
    parameter int PAT_LEN = 4,
    parameter int NUM_PAT = 2,
    parameter int CNT_W   = 8
) (
    input  logic                       ck,
    input  logic                       rs,
    input  logic                       data_valid,
    input  logic                       data,
    input  logic [NUM_PAT*PAT_LEN-1:0] pat_cfg,
    input  logic [NUM_PAT-1:0]         pat_en,
    input  logic                       overlap,
    input  logic                       cnt_clr,
    output logic [NUM_PAT-1:0]         y,
    output logic                       any_hit,
    output logic [NUM_PAT*CNT_W-1:0]   hit_cnt
);
    localparam int FW = $clog2(PAT_LEN);
    localparam logic [FW-1:0] FMAX = FW'(PAT_LEN - 1);

    logic [PAT_LEN-2:0]               hist;
    logic [NUM_PAT-1:0][FW-1:0]       fill, fill_nx;
    logic [NUM_PAT-1:0][CNT_W-1:0]    cnt, cnt_nx;
    logic [NUM_PAT-1:0]               match;

    // fill counts usable history bits per pattern; a consumed match restarts it
    always_comb begin
        for (int i = 0; i < NUM_PAT; i++) begin
            match[i]   = data_valid && pat_en[i] && fill[i] == FMAX &&
                         {hist, data} == pat_cfg[i*PAT_LEN +: PAT_LEN];
            fill_nx[i] = !pat_en[i] ? '0 :
                         !data_valid ? fill[i] :
                         (match[i] && !overlap) ? '0 :
                         (fill[i] == FMAX) ? FMAX : fill[i] + FW'(1);
            cnt_nx[i]  = cnt_clr ? '0 :
                         (match[i] && cnt[i] != '1) ? cnt[i] + CNT_W'(1) : cnt[i];
        end
    end

    always_ff @(posedge ck or negedge rs) begin
        if (!rs) begin
            hist    <= '0;
            fill    <= '0;
            cnt     <= '0;
            y       <= '0;
            any_hit <= 1'b0;
        end else begin
            hist    <= data_valid ? (PAT_LEN-1)'({hist, data}) : hist;
            fill    <= fill_nx;
            cnt     <= cnt_nx;
            y       <= match;
            any_hit <= |match;
        end
    end

    assign hit_cnt = cnt;
endmodule

// File: tb/tb_seq_detect_multi.sv
// tb_seq_detect_multi: directed scenarios plus randomized traffic against a
// bit-history reference model, on an 8-bit-counter and a 2-bit-counter instance.
module tb_seq_detect_multi;
    localparam int PL = 4;
    localparam int NP = 2;

    logic          ck = 1'b0, rs = 1'b0;
    logic          data_valid = 1'b0, data = 1'b0, overlap = 1'b1, cnt_clr = 1'b0;
    logic [NP*PL-1:0] pat_cfg = {4'b1011, 4'b1100};
    logic [NP-1:0] pat_en = 2'b11;
    logic [NP-1:0] y8, y2;
    logic          any8, any2;
    logic [NP*8-1:0] cnt8;
    logic [NP*2-1:0] cnt2;

    int checks = 0, errors = 0;
    bit hq[$];
    int seen[NP];
    int ec8[NP], ec2[NP];
    logic [NP-1:0] ey;
    logic eany;

    seq_detect_multi #(.PAT_LEN(PL), .NUM_PAT(NP), .CNT_W(8)) dut8 (
        .ck(ck), .rs(rs), .data_valid(data_valid), .data(data), .pat_cfg(pat_cfg),
        .pat_en(pat_en), .overlap(overlap), .cnt_clr(cnt_clr),
        .y(y8), .any_hit(any8), .hit_cnt(cnt8));

    seq_detect_multi #(.PAT_LEN(PL), .NUM_PAT(NP), .CNT_W(2)) dut2 (
        .ck(ck), .rs(rs), .data_valid(data_valid), .data(data), .pat_cfg(pat_cfg),
        .pat_en(pat_en), .overlap(overlap), .cnt_clr(cnt_clr),
        .y(y2), .any_hit(any2), .hit_cnt(cnt2));

    always #5 ck = ~ck;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // a pattern matches when its last PL valid bits (seen since enable or last consume) equal it
    function automatic logic [NP-1:0] model_match();
        logic [NP-1:0] m = '0;
        for (int i = 0; i < NP; i++) begin
            int v = 0;
            if (data_valid && pat_en[i] && seen[i] >= PL - 1) begin
                for (int k = PL - 1; k >= 1; k--) v = (v << 1) | int'(hq[hq.size() - k]);
                v = (v << 1) | int'(data);
                m[i] = (v == int'(pat_cfg[i*PL +: PL]));
            end
        end
        return m;
    endfunction

    task automatic model_reset();
        hq.delete();
        for (int i = 0; i < NP; i++) begin
            seen[i] = 0; ec8[i] = 0; ec2[i] = 0;
        end
        ey = '0;
        eany = 1'b0;
    endtask

    task automatic model_update(input logic [NP-1:0] m);
        ey = m;
        eany = |m;
        for (int i = 0; i < NP; i++) begin
            if (cnt_clr) begin
                ec8[i] = 0; ec2[i] = 0;
            end else if (m[i]) begin
                if (ec8[i] < 255) ec8[i]++;
                if (ec2[i] < 3) ec2[i]++;
            end
            if (!pat_en[i]) seen[i] = 0;
            else if (data_valid) seen[i] = (m[i] && !overlap) ? 0 : seen[i] + 1;
        end
        if (data_valid) begin
            hq.push_back(data);
            if (hq.size() > PL) void'(hq.pop_front());
        end
    endtask

    task automatic compare();
        check("y8", y8, ey);
        check("any8", any8, eany);
        check("cnt8", cnt8, {ec8[1][7:0], ec8[0][7:0]});
        check("y2", y2, ey);
        check("any2", any2, eany);
        check("cnt2", cnt2, {ec2[1][1:0], ec2[0][1:0]});
    endtask

    task automatic step(input logic v, input logic d, input logic clr);
        logic [NP-1:0] m;
        data_valid = v;
        data = d;
        cnt_clr = clr;
        m = model_match();
        @(posedge ck);
        model_update(m);
        #1;
        compare();
    endtask

    task automatic send(input logic [15:0] bits, input int n);
        for (int k = n - 1; k >= 0; k--) step(1'b1, bits[k], 1'b0);
    endtask

    // pulse rs between edges; outputs must clear without a clock edge
    task automatic async_reset();
        #2;
        rs = 1'b0;
        #1;
        model_reset();
        compare();
        #1;
        rs = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge ck);
        #1;
        compare();
        rs = 1'b1;

        send(16'b101100, 6);
        check("basic_cnt", cnt8, 16'h0101);
        async_reset();

        send(16'b1011011, 7);
        check("ovl1_cnt", cnt8, 16'h0200);
        async_reset();
        overlap = 1'b0;
        send(16'b1011011, 7);
        check("ovl0_cnt", cnt8, 16'h0100);
        async_reset();

        send(16'b10, 2);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        send(16'b11, 2);
        check("gap_y", y8, 2'b10);
        async_reset();

        repeat (5) send(16'b1011, 4);
        check("sat_cnt2", cnt2[3:2], 2'd3);
        send(16'b101, 3);
        step(1'b1, 1'b1, 1'b1);
        check("clr_y", y8, 2'b10);
        check("clr_cnt", cnt8, 16'h0000);

        send(16'b101, 3);
        async_reset();
        send(16'b1011, 4);
        send(16'b1011, 4);

        overlap = 1'b1;
        pat_en = 2'b10;
        send(16'b1100, 4);
        pat_en = 2'b11;
        pat_cfg[3:0] = 4'b1111;
        send(16'b1111, 4);
        check("reconf_y", y8[0], 1'b1);

        repeat (270) step(1'b1, 1'b1, 1'b0);
        check("sat_cnt8", cnt8[7:0], 8'hff);
        step(1'b1, 1'b1, 1'b1);

        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(99) < 5) pat_cfg = NP*PL'($urandom);
            if ($urandom_range(99) < 4) pat_en[$urandom_range(NP-1)] ^= 1'b1;
            if ($urandom_range(99) < 8) overlap = 1'($urandom);
            if ($urandom_range(999) < 3) async_reset();
            step($urandom_range(99) < 80, 1'($urandom), $urandom_range(99) < 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
